// File: rtl/alu_seq_nbit.sv
// ---------------------------------------------------------------------------
// alu_seq_nbit
//   Registered N-bit ALU with a start/busy/done handshake. Single-cycle
//   operations: AND, OR, ADD, SUB and signed SLT. Optional multi-cycle
//   radix-2 shift-add unsigned multiplier (MUL).
//
//   Optional feature macro: ALU_MUL_EN
//     defined   -> opcode 3'b011 runs the WIDTH-cycle multiplier.
//     undefined -> 3'b011 is illegal (zero result, 1-cycle done), busy and
//                  outp_hi are tied to 0, and no multiplier logic exists.
//
// Parameters:
//   WIDTH    operand/result width (4..64)
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   start    operation request, sampled only while busy=0
//   aluop    operation select
//   ai, bi   operands A and B
//   cin      carry-in (ADD only)
//   outp     result / low half of MUL product
//   outp_hi  high half of MUL product, 0 otherwise
//   cout     adder carry out (SUB: 1 = no borrow)
//   ovf      signed overflow for ADD/SUB
//   zero     high when outp == 0
//   busy     high while a MUL is iterating
//   done     one-cycle pulse when a result is written
// ---------------------------------------------------------------------------
module alu_seq_nbit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] ai,
  input  logic [WIDTH-1:0] bi,
  input  logic             cin,
  output logic [WIDTH-1:0] outp,
  output logic [WIDTH-1:0] outp_hi,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Shared adders: one for ADD, one for SUB/SLT (carry-in forced to 1).
  logic [WIDTH:0]   sum_add_s;
  logic [WIDTH:0]   sum_sub_s;
  logic             ovf_add_s;
  logic             ovf_sub_s;

  // Single-cycle result, captured into the output registers on accept.
  logic [WIDTH-1:0] res_d;
  logic             cout_d;
  logic             ovf_d;

  logic [WIDTH-1:0] outp_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             done_q;

  assign sum_add_s = {1'b0, ai} + {1'b0, bi} + {{WIDTH{1'b0}}, cin};
  assign sum_sub_s = {1'b0, ai} + {1'b0, ~bi} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf_add_s = (ai[MSB] == bi[MSB]) && (sum_add_s[MSB] != ai[MSB]);
  assign ovf_sub_s = (ai[MSB] != bi[MSB]) && (sum_sub_s[MSB] != ai[MSB]);

  // Single-cycle operation decode; illegal codes yield an all-zero result.
  always_comb begin
    res_d  = {WIDTH{1'b0}};
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    case (aluop)
      OP_AND: res_d = ai & bi;
      OP_OR:  res_d = ai | bi;
      OP_ADD: begin
        res_d  = sum_add_s[MSB:0];
        cout_d = sum_add_s[WIDTH];
        ovf_d  = ovf_add_s;
      end
      OP_SUB: begin
        res_d  = sum_sub_s[MSB:0];
        cout_d = sum_sub_s[WIDTH];
        ovf_d  = ovf_sub_s;
      end
      // Signed less-than: sign of the difference corrected by overflow.
      OP_SLT: res_d = {{(WIDTH-1){1'b0}}, sum_sub_s[MSB] ^ ovf_sub_s};
      default: begin
        res_d  = {WIDTH{1'b0}};
        cout_d = 1'b0;
        ovf_d  = 1'b0;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam int         CNT_W  = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] outp_hi_q;
  logic             busy_q;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mplier_d;

  // One shift-add step: {acc, mplier} ends up holding the 2*WIDTH product,
  // the multiplier being shifted out while product bits shift in above it.
  always_comb begin
    if (mplier_q[0]) begin
      mul_sum_s = {1'b0, acc_q} + {1'b0, mcand_q};
    end else begin
      mul_sum_s = {1'b0, acc_q};
    end
    acc_d    = mul_sum_s[WIDTH:1];
    mplier_d = {mul_sum_s[0], mplier_q[MSB:1]};
  end

  // Control FSM plus registered outputs; start is ignored while in S_MUL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      acc_q     <= {WIDTH{1'b0}};
      outp_q    <= {WIDTH{1'b0}};
      outp_hi_q <= {WIDTH{1'b0}};
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && (aluop == OP_MUL)) begin
            state_q  <= S_MUL;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_W'(WIDTH);
            mcand_q  <= ai;
            mplier_q <= bi;
            acc_q    <= {WIDTH{1'b0}};
          end else if (start) begin
            outp_q    <= res_d;
            outp_hi_q <= {WIDTH{1'b0}};
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= (res_d == {WIDTH{1'b0}});
            done_q    <= 1'b1;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          // Last iteration: publish the step's result directly.
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            outp_q    <= mplier_d;
            outp_hi_q <= acc_d;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= (mplier_d == {WIDTH{1'b0}});
            done_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign outp_hi = outp_hi_q;
  assign busy    = busy_q;
`else
  // Output registers: every start is a single-cycle op when MUL is absent.
  always_ff @(posedge clk) begin
    if (reset) begin
      outp_q <= {WIDTH{1'b0}};
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= start;
      if (start) begin
        outp_q <= res_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= (res_d == {WIDTH{1'b0}});
      end
    end
  end

  assign outp_hi = {WIDTH{1'b0}};
  assign busy    = 1'b0;
`endif

  assign outp = outp_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu_seq_nbit.sv
module tb_alu_seq_nbit;
  localparam int W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_MUL = 3'b011;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   aluop;
  logic [W-1:0] ai;
  logic [W-1:0] bi;
  logic         cin;
  logic [W-1:0] outp;
  logic [W-1:0] outp_hi;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Expected architectural outputs, maintained by the reference model.
  logic [W-1:0] exp_r  = '0;
  logic [W-1:0] exp_hi = '0;
  logic         exp_co = 1'b0;
  logic         exp_ov = 1'b0;

  alu_seq_nbit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .aluop   (aluop),
    .ai      (ai),
    .bi      (bi),
    .cin     (cin),
    .outp    (outp),
    .outp_hi (outp_hi),
    .cout    (cout),
    .ovf     (ovf),
    .zero    (zero),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model from the arithmetic definition of each operation.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    longint          sa, sb, sr, lim_max, lim_min;
    longint unsigned ua, ub, us;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    lim_max = (longint'(1) <<< (W - 1)) - longint'(1);
    lim_min = -(longint'(1) <<< (W - 1));
    exp_r = '0; exp_hi = '0; exp_co = 1'b0; exp_ov = 1'b0;
    case (op)
      OP_AND: exp_r = a & b;
      OP_OR:  exp_r = a | b;
      OP_ADD: begin
        us = ua + ub + longint'(c);
        exp_r  = us[W-1:0];
        exp_co = us[W];
        sr = sa + sb + longint'(c);
        exp_ov = (sr > lim_max) || (sr < lim_min);
      end
      OP_SUB: begin
        exp_r  = a - b;
        exp_co = (a >= b);
        sr = sa - sb;
        exp_ov = (sr > lim_max) || (sr < lim_min);
      end
      OP_SLT: exp_r[0] = (sa < sb);
`ifdef ALU_MUL_EN
      OP_MUL: begin
        us = ua * ub;
        exp_r  = us[W-1:0];
        exp_hi = us[2*W-1:W];
      end
`endif
      default: exp_r = '0;
    endcase
  endtask

  task automatic check_result(input string tag);
    check({tag, "_outp"},    outp,    exp_r);
    check({tag, "_outp_hi"}, outp_hi, exp_hi);
    check({tag, "_cout"},    cout,    exp_co);
    check({tag, "_ovf"},     ovf,     exp_ov);
    check({tag, "_zero"},    zero,    (exp_r == '0));
  endtask

  // Issue one single-cycle op at a falling edge; check one cycle later.
  task automatic single_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input string tag);
    aluop = op; ai = a; bi = b; cin = c; start = 1'b1;
    model(op, a, b, c);
    @(negedge clk);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check_result(tag);
  endtask

  task automatic directed(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] want, input string tag);
    single_op(op, a, b, c, tag);
    check({tag, "_lit"}, outp, want);
  endtask

  // Drop start for a cycle: no done, outputs hold.
  task automatic idle_check(input string tag);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_idle_done"}, done, 1'b0);
    check_result({tag, "_hold"});
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

`ifdef ALU_MUL_EN
  // Run a MUL; optionally pulse start mid-operation, which must be ignored.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject,
                         input string tag);
    int lat, busy_cnt;
    aluop = OP_MUL; ai = a; bi = b; cin = 1'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 4 * W) begin
      if (inject && lat == 5) begin
        start = 1'b1; aluop = OP_AND; ai = '1; bi = '1;
      end else if (inject && lat == 6) begin
        start = 1'b0;
      end
      if (lat == W / 2) check_result({tag, "_midhold"});
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    model(OP_MUL, a, b, 1'b0);
    check({tag, "_latency"}, lat, W);
    check({tag, "_busycycles"}, busy_cnt, W);
    check({tag, "_busy_end"}, busy, 1'b0);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_once"}, done, 1'b0);
    check_result({tag, "_after"});
  endtask

  task automatic reset_mid_mul();
    int dones;
    aluop = OP_MUL; ai = '1; bi = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_busy_before", busy, 1'b1);
    // Reset with a concurrent start: reset wins.
    reset = 1'b1; start = 1'b1; aluop = OP_AND; ai = '1; bi = '1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    exp_r = '0; exp_hi = '0; exp_co = 1'b0; exp_ov = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check_result("rst");
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("rst_no_done", dones, 0);
    directed(OP_AND, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 32'h0000_FFFF, "rst_and");
    start = 1'b0;
  endtask
`endif

  initial begin
    logic [2:0] ops [8];
    logic [2:0] op;
    ops[0] = OP_AND; ops[1] = OP_OR;  ops[2] = OP_ADD; ops[3] = OP_SUB;
    ops[4] = OP_SLT; ops[5] = OP_MUL; ops[6] = 3'b100; ops[7] = 3'b101;

    reset = 1'b1; start = 1'b0; aluop = 3'b000; ai = '0; bi = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check_result("reset");
    reset = 1'b0;

    // Directed cases
    directed(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, "add_ff");
    check("add_ff_cout_lit", cout, 1'b1);
    check("add_ff_ovf_lit", ovf, 1'b0);
    directed(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, "add_ovf");
    check("add_ovf_lit", ovf, 1'b1);
    directed(OP_ADD, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0009, "add_cin");
    directed(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, "sub_borrow");
    check("sub_borrow_cout_lit", cout, 1'b0);
    check("sub_borrow_zero_lit", zero, 1'b0);
    directed(OP_SUB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, "sub_eq");
    check("sub_eq_cout_lit", cout, 1'b1);
    check("sub_eq_zero_lit", zero, 1'b1);
    directed(OP_SLT, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0001, "slt_0_1");
    directed(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0001, "slt_m1_0");
    directed(OP_SLT, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, "slt_1_0");
    directed(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, "slt_minmax");
    directed(OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 32'hF0F0_0F0F, "or_basic");
    directed(3'b100, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h0000_0000, "illegal_100");
    idle_check("directed");

`ifdef ALU_MUL_EN
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mul_ff");
    check("mul_ff_hi_lit", outp_hi, 32'hFFFF_FFFE);
    check("mul_ff_lo_lit", outp, 32'h0000_0001);
    run_mul(32'h0000_0000, 32'h1234_5678, 1'b0, "mul_zero");
    reset_mid_mul();
`else
    directed(OP_MUL, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0000, "mul_disabled");
    idle_check("mul_disabled");
`endif

    // Randomised stream, single-cycle ops back-to-back with occasional gaps.
    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 7)];
`ifdef ALU_MUL_EN
      if (op == OP_MUL) begin
        run_mul(rnd_val(), rnd_val(), 1'($urandom), "rnd_mul");
      end else begin
        single_op(op, rnd_val(), rnd_val(), 1'($urandom), "rnd");
      end
`else
      single_op(op, rnd_val(), rnd_val(), 1'($urandom), "rnd");
`endif
      if ($urandom_range(0, 3) == 0) idle_check("rnd");
    end
    idle_check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
